// File: rtl/interrupt_controller.sv
// Three-line interrupt controller: synchronise, edge-detect, latch pending,
// mask, fixed-priority arbitration (line 0 highest) and a req/ack/done
// handshake with the control unit. All outputs come straight from flops.
module interrupt_controller #(
  parameter int                  PC_WIDTH      = 10,
  parameter logic [PC_WIDTH-1:0] VECTOR_BASE   = PC_WIDTH'(10'h3F0),
  parameter int                  VECTOR_STRIDE = 4,
  parameter logic [2:0]          MASK_RESET    = 3'b111
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          interrupciones,
  input  logic                mask_we,
  input  logic [2:0]          mask_in,
  input  logic                int_ack,
  input  logic                int_done,
  output logic                int_req,
  output logic [PC_WIDTH-1:0] int_vector,
  output logic [1:0]          int_id,
  output logic                in_service,
  output logic [2:0]          pending,
  output logic [2:0]          mask
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Handler address; the sum wraps naturally at PC_WIDTH bits.
  function automatic logic [PC_WIDTH-1:0] vector_addr(input logic [1:0] id);
    return VECTOR_BASE + PC_WIDTH'(id) * PC_WIDTH'(VECTOR_STRIDE);
  endfunction

  // Fixed priority, lowest index wins. Only called with a non-zero vector.
  function automatic logic [1:0] pick_winner(input logic [2:0] elig);
    if (elig[0])      return 2'd0;
    else if (elig[1]) return 2'd1;
    else              return 2'd2;
  endfunction

  logic [2:0]          sync_p0_q, sync_p1_q, sync_p2_q;
  logic [2:0]          rise_p2;
  logic [2:0]          pending_q, pending_d;
  logic [2:0]          mask_q, mask_d;
  logic [2:0]          eligible;
  logic [2:0]          clr;
  logic                ack_fire;
  logic [1:0]          winner;
  state_t              state_q, state_d;
  logic                int_req_q, int_req_d;
  logic                in_service_q, in_service_d;
  logic [1:0]          int_id_q, int_id_d;
  logic [PC_WIDTH-1:0] int_vector_q, int_vector_d;

  // Stage p0/p1: two-flop synchroniser; p2: history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0_q <= '0;
      sync_p1_q <= '0;
      sync_p2_q <= '0;
    end else begin
      sync_p0_q <= interrupciones;
      sync_p1_q <= sync_p0_q;
      sync_p2_q <= sync_p1_q;
    end
  end

  assign rise_p2 = sync_p1_q & ~sync_p2_q;

  // Pending/mask next state: a new edge wins over the acknowledge clear.
  always_comb begin
    ack_fire  = (state_q == REQUEST) && int_ack;
    clr       = ack_fire ? (3'b001 << int_id_q) : 3'b000;
    pending_d = (pending_q & ~clr) | rise_p2;
    mask_d    = mask_we ? mask_in : mask_q;
    eligible  = pending_q & mask_q;
    winner    = pick_winner(eligible);
  end

  // Handshake FSM next state; grant id and vector freeze once requested.
  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    in_service_d = in_service_q;
    int_id_d     = int_id_q;
    int_vector_d = int_vector_q;
    case (state_q)
      IDLE: begin
        if (eligible != 3'b000) begin
          state_d      = REQUEST;
          int_req_d    = 1'b1;
          int_id_d     = winner;
          int_vector_d = vector_addr(winner);
        end
      end
      REQUEST: begin
        if (int_ack) begin
          state_d      = SERVICE;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
        end
      end
      SERVICE: begin
        if (int_done) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  // Stage p3: pending, mask, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= '0;
      mask_q       <= MASK_RESET;
      state_q      <= IDLE;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      int_id_q     <= 2'd0;
      int_vector_q <= VECTOR_BASE;
    end else begin
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      in_service_q <= in_service_d;
      int_id_q     <= int_id_d;
      int_vector_q <= int_vector_d;
    end
  end

  assign int_req    = int_req_q;
  assign int_vector = int_vector_q;
  assign int_id     = int_id_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule
